// File: rtl/exe_mem_skid_reg_if.sv
// exe_mem_skid_reg_if
//   EXE->MEM stage bus. It carries the upstream (EXE) valid/ready handshake
//   with its payload and the downstream (MEM) valid/ready handshake with its
//   payload.
//   slave  : the stage register. It receives in_* and out_ready, and it
//            drives in_ready and out_*.
//   master : the environment (EXE and MEM together). It uses the opposite
//            directions.
interface exe_mem_skid_reg_if #(
  parameter int unsigned CTRL_W = 3,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEST_W = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_alu;
  logic [DATA_W-1:0] in_val2;
  logic [DEST_W-1:0] in_dest;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_alu;
  logic [DATA_W-1:0] out_val2;
  logic [DEST_W-1:0] out_dest;

  modport slave (
    input  in_valid, in_ctrl, in_alu, in_val2, in_dest, out_ready,
    output in_ready, out_valid, out_ctrl, out_alu, out_val2, out_dest
  );

  modport master (
    output in_valid, in_ctrl, in_alu, in_val2, in_dest, out_ready,
    input  in_ready, out_valid, out_ctrl, out_alu, out_val2, out_dest
  );
endinterface

// File: rtl/exe_mem_skid_reg.sv
// exe_mem_skid_reg
//   Elastic EXE->MEM pipeline register with valid/ready handshakes on both
//   sides.
//   SKID_EN=1 : a 2-entry skid buffer. Register M drives the outputs and
//               register S catches one extra entry, so in_ready depends only
//               on registered state.
//   SKID_EN=0 : a single register. Its ready is passed combinationally from
//               out_ready.
//   Priority  : rst_n > flush > freeze > normal operation.
//   out_ctrl is forced to zero whenever out_valid is low, so a bubble can
//   never write.
// Ports
//   clk, rst_n : clock, and asynchronous active-low reset.
//   flush      : synchronous kill of all held entries.
//   freeze     : hold all state and block both handshakes.
//   bus        : exe_mem_skid_reg_if.slave (in_* / out_* handshakes).
//   occupancy  : registered count of valid held entries.
module exe_mem_skid_reg #(
  parameter int unsigned CTRL_W  = 3,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DEST_W  = 4,
  parameter int unsigned SKID_EN = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  freeze,
  exe_mem_skid_reg_if.slave     bus,
  output logic [1:0]            occupancy
);

  localparam int unsigned ENT_W = CTRL_W + 2 * DATA_W + DEST_W;

  logic             m_valid_q, m_valid_d;
  logic             s_valid_q, s_valid_d;
  logic [ENT_W-1:0] m_q, m_d;
  logic [ENT_W-1:0] s_q, s_d;
  logic [1:0]       occ_q, occ_d;

  logic [ENT_W-1:0] in_ent;
  logic             out_valid;
  logic             in_ready;
  logic             accept;
  logic             drain;

  assign in_ent = {bus.in_ctrl, bus.in_alu, bus.in_val2, bus.in_dest};

  assign out_valid = m_valid_q & ~freeze;

  // With the skid buffer, readiness depends only on the registered S slot.
  // Without it, a full M can still accept when MEM drains in the same cycle.
  assign in_ready = ((SKID_EN != 0) ? ~s_valid_q : (~m_valid_q | bus.out_ready))
                    & ~freeze & ~flush;

  assign accept = bus.in_valid & in_ready;
  assign drain  = out_valid & bus.out_ready;

  always_comb begin
    m_valid_d = m_valid_q;
    s_valid_d = s_valid_q;
    m_d       = m_q;
    s_d       = s_q;
    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (!freeze) begin
      if (SKID_EN != 0) begin
        if (!m_valid_q) begin
          if (accept) begin
            m_d       = in_ent;
            m_valid_d = 1'b1;
          end
        end else if (!s_valid_q) begin
          if (accept && drain) begin
            m_d = in_ent;
          end else if (accept) begin
            s_d       = in_ent;
            s_valid_d = 1'b1;
          end else if (drain) begin
            m_valid_d = 1'b0;
          end
        end else if (drain) begin
          // Both slots are full and in_ready is low: promote S into M.
          m_d       = s_q;
          s_valid_d = 1'b0;
        end
      end else begin
        if (accept) begin
          m_d       = in_ent;
          m_valid_d = 1'b1;
        end else if (drain) begin
          m_valid_d = 1'b0;
        end
      end
    end
    occ_d = {1'b0, m_valid_d} + {1'b0, s_valid_d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
      m_q       <= '0;
      s_q       <= '0;
      occ_q     <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      s_valid_q <= s_valid_d;
      m_q       <= m_d;
      s_q       <= s_d;
      occ_q     <= occ_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_ctrl  = out_valid ? m_q[ENT_W-1 -: CTRL_W] : '0;
  assign bus.out_alu   = m_q[2*DATA_W+DEST_W-1 -: DATA_W];
  assign bus.out_val2  = m_q[DATA_W+DEST_W-1 -: DATA_W];
  assign bus.out_dest  = m_q[DEST_W-1:0];
  assign occupancy     = occ_q;

endmodule

// File: tb/tb_exe_mem_skid_reg.sv
module tb_exe_mem_skid_reg;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       freeze;
  logic [1:0] occ1;
  logic [1:0] occ0;

  int unsigned n_checks;
  int unsigned n_pass;

  exe_mem_skid_reg_if #(.CTRL_W(3), .DATA_W(32), .DEST_W(4)) bus1 ();
  exe_mem_skid_reg_if #(.CTRL_W(3), .DATA_W(32), .DEST_W(4)) bus0 ();

  exe_mem_skid_reg #(.CTRL_W(3), .DATA_W(32), .DEST_W(4), .SKID_EN(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .freeze(freeze),
    .bus(bus1), .occupancy(occ1)
  );

  exe_mem_skid_reg #(.CTRL_W(3), .DATA_W(32), .DEST_W(4), .SKID_EN(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .freeze(freeze),
    .bus(bus0), .occupancy(occ0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  ctrl;
    logic [31:0] alu;
    logic [31:0] val2;
    logic [3:0]  dest;
  } ent_t;

  typedef struct {
    logic        iv;
    logic [2:0]  ctl;
    logic [31:0] alu;
    logic        ordy;
    logic        fl;
    logic        fz;
    logic        e_ir;
    logic        e_ov;
    logic [2:0]  e_ctl;
    logic [31:0] e_alu;
    logic [1:0]  e_occ;
  } vec_t;

  vec_t tbl[24];
  ent_t q0[$];
  ent_t q1[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic drv1(input logic iv, input logic [2:0] ctl, input logic [31:0] alu, input logic ordy);
    bus1.in_valid  = iv;
    bus1.in_ctrl   = ctl;
    bus1.in_alu    = alu;
    bus1.in_val2   = alu ^ 32'h5555_0000;
    bus1.in_dest   = alu[3:0];
    bus1.out_ready = ordy;
  endtask

  task automatic drv0(input logic iv, input logic [2:0] ctl, input logic [31:0] alu, input logic ordy);
    bus0.in_valid  = iv;
    bus0.in_ctrl   = ctl;
    bus0.in_alu    = alu;
    bus0.in_val2   = alu ^ 32'h5555_0000;
    bus0.in_dest   = alu[3:0];
    bus0.out_ready = ordy;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference: each stage is a FIFO with capacity 2 (skid) or 1 (plain).
  // The plain register can refill in the same cycle that MEM takes its entry.
  task automatic model_step(input string tag, input bit skid, input logic iv, input ent_t in_e,
                            input logic ordy, input logic a_ir, input logic a_ov,
                            input ent_t a_out, input logic [1:0] a_occ);
    ent_t q[$];
    logic e_ir;
    logic e_ov;
    if (skid) q = q1; else q = q0;
    e_ov = (q.size() > 0) && !freeze;
    if (skid) e_ir = (q.size() < 2) && !freeze && !flush;
    else      e_ir = ((q.size() == 0) || ordy) && !freeze && !flush;
    chk({tag, ".in_ready"},  32'(a_ir),  32'(e_ir));
    chk({tag, ".out_valid"}, 32'(a_ov),  32'(e_ov));
    chk({tag, ".occupancy"}, 32'(a_occ), q.size());
    chk({tag, ".out_ctrl"},  32'(a_out.ctrl), e_ov ? 32'(q[0].ctrl) : 32'd0);
    if (e_ov) begin
      chk({tag, ".out_alu"},  a_out.alu,  q[0].alu);
      chk({tag, ".out_val2"}, a_out.val2, q[0].val2);
      chk({tag, ".out_dest"}, 32'(a_out.dest), 32'(q[0].dest));
    end
    if (flush) q.delete();
    else if (!freeze) begin
      if (e_ov && ordy) void'(q.pop_front());
      if (iv && e_ir) q.push_back(in_e);
    end
    if (skid) q1 = q; else q0 = q;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    flush    = 1'b0;
    freeze   = 1'b0;
    drv1(1'b0, 3'd0, 32'd0, 1'b0);
    drv0(1'b0, 3'd0, 32'd0, 1'b0);

    //            iv   ctl   alu    ordy fl  fz   e_ir e_ov e_ctl e_alu  e_occ
    tbl[0]  = '{1'b1, 3'd1, 32'h10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 32'h0,  2'd0};
    tbl[1]  = '{1'b1, 3'd1, 32'h11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 32'h10, 2'd1};
    tbl[2]  = '{1'b1, 3'd1, 32'h12, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 32'h11, 2'd1};
    tbl[3]  = '{1'b0, 3'd0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 32'h12, 2'd1};
    tbl[4]  = '{1'b1, 3'd1, 32'hA,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 32'h0,  2'd0};
    tbl[5]  = '{1'b1, 3'd1, 32'hB,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 32'hA,  2'd1};
    tbl[6]  = '{1'b0, 3'd0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 32'hA,  2'd2};
    tbl[7]  = '{1'b0, 3'd0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 32'hA,  2'd2};
    tbl[8]  = '{1'b0, 3'd0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 32'hB,  2'd1};
    tbl[9]  = '{1'b0, 3'd0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 32'h0,  2'd0};
    tbl[10] = '{1'b1, 3'd5, 32'h20, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 32'h0,  2'd0};
    tbl[11] = '{1'b1, 3'd5, 32'h21, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd5, 32'h20, 2'd1};
    tbl[12] = '{1'b1, 3'd1, 32'hC,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd5, 32'h20, 2'd2};
    tbl[13] = '{1'b0, 3'd0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 32'h0,  2'd0};
    tbl[14] = '{1'b0, 3'd0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 32'h0,  2'd0};
    tbl[15] = '{1'b1, 3'd1, 32'h30, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 32'h0,  2'd0};
    tbl[16] = '{1'b1, 3'd1, 32'h99, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0,  2'd1};
    tbl[17] = '{1'b0, 3'd0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0,  2'd1};
    tbl[18] = '{1'b0, 3'd0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0,  2'd1};
    tbl[19] = '{1'b0, 3'd0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 32'h30, 2'd1};
    tbl[20] = '{1'b0, 3'd0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 32'h0,  2'd0};
    tbl[21] = '{1'b1, 3'd1, 32'h40, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 32'h0,  2'd0};
    tbl[22] = '{1'b0, 3'd0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0,  2'd1};
    tbl[23] = '{1'b0, 3'd0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 32'h0,  2'd0};

    // Reset state.
    #1;
    chk("rst.occ1",     32'(occ1),           32'd0);
    chk("rst.out_valid1", 32'(bus1.out_valid), 32'd0);
    chk("rst.out_ctrl1",  32'(bus1.out_ctrl),  32'd0);
    chk("rst.occ0",     32'(occ0),           32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
    chk("rst.in_ready1", 32'(bus1.in_ready), 32'd1);
    chk("rst.in_ready0", 32'(bus0.in_ready), 32'd1);

    // Directed vectors on the skid variant.
    for (int i = 0; i < 24; i++) begin
      drv1(tbl[i].iv, tbl[i].ctl, tbl[i].alu, tbl[i].ordy);
      flush  = tbl[i].fl;
      freeze = tbl[i].fz;
      @(negedge clk);
      chk($sformatf("vec%0d.in_ready", i),  32'(bus1.in_ready),  32'(tbl[i].e_ir));
      chk($sformatf("vec%0d.out_valid", i), 32'(bus1.out_valid), 32'(tbl[i].e_ov));
      chk($sformatf("vec%0d.out_ctrl", i),  32'(bus1.out_ctrl),  32'(tbl[i].e_ctl));
      chk($sformatf("vec%0d.occupancy", i), 32'(occ1),           32'(tbl[i].e_occ));
      if (tbl[i].e_ov) chk($sformatf("vec%0d.out_alu", i), bus1.out_alu, tbl[i].e_alu);
      next_cycle();
    end
    flush  = 1'b0;
    freeze = 1'b0;

    // Reset while two entries are held.
    drv1(1'b1, 3'd1, 32'h60, 1'b0);
    next_cycle();
    drv1(1'b1, 3'd1, 32'h61, 1'b0);
    next_cycle();
    drv1(1'b0, 3'd0, 32'h0, 1'b0);
    next_cycle();
    chk("midrst.pre_occ", 32'(occ1), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst.occ",       32'(occ1),           32'd0);
    chk("midrst.out_valid", 32'(bus1.out_valid), 32'd0);
    chk("midrst.out_ctrl",  32'(bus1.out_ctrl),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
    chk("midrst.in_ready", 32'(bus1.in_ready), 32'd1);

    // Plain register: fill under backpressure, then drain and refill together.
    drv0(1'b1, 3'd1, 32'h50, 1'b0);
    @(negedge clk);
    chk("plain.ready_empty", 32'(bus0.in_ready), 32'd1);
    next_cycle();
    drv0(1'b0, 3'd0, 32'h0, 1'b0);
    @(negedge clk);
    chk("plain.ready_full", 32'(bus0.in_ready), 32'd0);
    chk("plain.occ_full",   32'(occ0),          32'd1);
    chk("plain.alu50",      bus0.out_alu,       32'h50);
    next_cycle();
    drv0(1'b1, 3'd1, 32'h51, 1'b1);
    @(negedge clk);
    chk("plain.ready_pass", 32'(bus0.in_ready), 32'd1);
    next_cycle();
    drv0(1'b0, 3'd0, 32'h0, 1'b0);
    @(negedge clk);
    chk("plain.occ_refill", 32'(occ0),           32'd1);
    chk("plain.alu51",      bus0.out_alu,        32'h51);
    chk("plain.valid51",    32'(bus0.out_valid), 32'd1);
    next_cycle();
    drv0(1'b0, 3'd0, 32'h0, 1'b1);
    next_cycle();
    drv0(1'b0, 3'd0, 32'h0, 1'b0);
    @(negedge clk);
    chk("plain.occ_drained", 32'(occ0), 32'd0);
    next_cycle();

    // Random traffic on both variants against the FIFO reference.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    q0.delete();
    q1.delete();
    for (int c = 0; c < 600; c++) begin
      flush  = ($urandom_range(0, 24) == 0);
      freeze = ($urandom_range(0, 9) == 0);
      drv1(1'($urandom_range(0, 1)), 3'($urandom), $urandom, ($urandom_range(0, 9) < 7));
      drv0(1'($urandom_range(0, 1)), 3'($urandom), $urandom, ($urandom_range(0, 9) < 6));
      @(negedge clk);
      model_step("rnd.skid", 1'b1, bus1.in_valid,
                 '{bus1.in_ctrl, bus1.in_alu, bus1.in_val2, bus1.in_dest}, bus1.out_ready,
                 bus1.in_ready, bus1.out_valid,
                 '{bus1.out_ctrl, bus1.out_alu, bus1.out_val2, bus1.out_dest}, occ1);
      model_step("rnd.plain", 1'b0, bus0.in_valid,
                 '{bus0.in_ctrl, bus0.in_alu, bus0.in_val2, bus0.in_dest}, bus0.out_ready,
                 bus0.in_ready, bus0.out_valid,
                 '{bus0.out_ctrl, bus0.out_alu, bus0.out_val2, bus0.out_dest}, occ0);
      next_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
